// File: rtl/std_mem_d1_copy.sv
// Copy engine between two std_mem_d1 instances: reads n words from the source
// and writes them to the same addresses in the destination, then pulses done.
module std_mem_d1_copy #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE:0]   len,
  output logic                done,
  output logic [IDX_SIZE-1:0] src_addr0,
  input  logic [WIDTH-1:0]    src_read_data,
  output logic [IDX_SIZE-1:0] dst_addr0,
  output logic [WIDTH-1:0]    dst_write_data,
  output logic                dst_write_en,
  input  logic                dst_done
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT, FIN} state_t;

  localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE+1)'(SIZE);
  localparam logic [IDX_SIZE:0] ONE    = (IDX_SIZE+1)'(1);

  state_t              state, state_nx;
  logic [IDX_SIZE:0]   idx, n, len_clamp, idx_inc;

  assign len_clamp = (len > SIZE_W) ? SIZE_W : len;
  assign idx_inc   = idx + ONE;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      n   <= '0;
    end else begin
      if (state == IDLE && go) begin
        n   <= len_clamp;
        idx <= '0;
      end else if (state == WAIT && dst_done) begin
        idx <= idx_inc;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = (len_clamp == '0) ? FIN : WRITE;
      WRITE:   state_nx = WAIT;
      WAIT:    if (dst_done) state_nx = (idx_inc == n) ? FIN : WRITE;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are masked by reset so an abort never leaks a write or a done.
  always_comb begin
    done         = 1'b0;
    dst_write_en = 1'b0;
    case (state)
      WRITE:   dst_write_en = !reset;
      FIN:     done         = !reset;
      default: ;
    endcase
  end

  assign src_addr0      = idx[IDX_SIZE-1:0];
  assign dst_addr0      = idx[IDX_SIZE-1:0];
  assign dst_write_data = src_read_data;

endmodule

// File: tb/tb_std_mem_d1_copy.sv
// Scoreboard bench for std_mem_d1_copy: stimulus predicts every write and the
// done cycle from the copy rules; a negedge monitor pops and compares.
module tb_std_mem_d1_copy;
  localparam int WIDTH = 32;
  localparam int SIZE  = 16;
  localparam int IDX   = 4;

  typedef struct {
    logic [IDX-1:0]   addr;
    logic [WIDTH-1:0] data;
    int               cyc;
  } wr_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             go = 1'b0;
  logic [IDX:0]     len = '0;
  logic             done;
  logic [IDX-1:0]   src_addr0, dst_addr0;
  logic [WIDTH-1:0] src_read_data, dst_write_data;
  logic             dst_write_en;
  logic             dst_done = 1'b0;
  logic             clr = 1'b0;

  logic [WIDTH-1:0] src_mem [SIZE];
  logic [WIDTH-1:0] dst_mem [SIZE];
  logic [WIDTH-1:0] ref_dst [SIZE];
  int               stall   [SIZE];

  wr_t exp_wr[$];
  int  exp_done[$];
  wr_t e;
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  pend_cnt = 0;
  logic pend = 1'b0;

  std_mem_d1_copy #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX)) dut (
    .clk(clk), .reset(reset), .go(go), .len(len), .done(done),
    .src_addr0(src_addr0), .src_read_data(src_read_data),
    .dst_addr0(dst_addr0), .dst_write_data(dst_write_data),
    .dst_write_en(dst_write_en), .dst_done(dst_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign src_read_data = src_mem[src_addr0];

  // Destination memory: done one cycle after write_en plus a per-address stall.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < SIZE; i++) dst_mem[i] <= 32'hA5A5_0000 + i;
    end
    if (reset) begin
      dst_done <= 1'b0;
      pend     <= 1'b0;
      pend_cnt <= 0;
    end else if (dst_write_en) begin
      dst_mem[dst_addr0] <= dst_write_data;
      if (stall[dst_addr0] == 0) begin
        dst_done <= 1'b1;
        pend     <= 1'b0;
      end else begin
        dst_done <= 1'b0;
        pend     <= 1'b1;
        pend_cnt <= stall[dst_addr0];
      end
    end else if (pend) begin
      if (pend_cnt == 1) begin
        dst_done <= 1'b1;
        pend     <= 1'b0;
      end
      pend_cnt <= pend_cnt - 1;
    end else begin
      dst_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (dst_write_en) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL write_en unexpected: cyc=%0d addr=%0d data=%h, required none", cyc, dst_addr0, dst_write_data);
      end else begin
        e = exp_wr.pop_front();
        if (dst_addr0 !== e.addr || dst_write_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   dst_addr0, dst_write_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL done unexpected: cyc=%0d, required none", cyc);
      end else if (exp_done[0] != cyc) begin
        errors++;
        $display("FAIL done cycle: got %0d, required %0d", cyc, exp_done[0]);
        void'(exp_done.pop_front());
      end else begin
        void'(exp_done.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic clear_dst();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < SIZE; i++) ref_dst[i] = 32'hA5A5_0000 + i;
  endtask

  // Predict the whole copy: word k issues 2 cycles after word k-1 plus its stall.
  task automatic start_copy(input int l);
    int  n, t;
    wr_t w;
    n = (l > SIZE) ? SIZE : l;
    t = cyc + 1;
    for (int k = 0; k < n; k++) begin
      w.addr = IDX'(k);
      w.data = src_mem[k];
      w.cyc  = t;
      exp_wr.push_back(w);
      ref_dst[k] = src_mem[k];
      t += 2 + stall[k];
    end
    exp_done.push_back(t);
    len = (IDX+1)'(l);
    go  = 1'b1;
    tick();
    go  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (exp_wr.size() != 0 || exp_done.size() != 0); i++) tick();
    if (exp_wr.size() != 0 || exp_done.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d writes and %0d dones outstanding, required 0", exp_wr.size(), exp_done.size());
      exp_wr.delete();
      exp_done.delete();
    end
    tick();
  endtask

  task automatic check_mem(input string nm);
    int bad;
    bad = -1;
    for (int i = SIZE - 1; i >= 0; i--) if (dst_mem[i] !== ref_dst[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s dst[%0d]: got %h, required %h", nm, bad, dst_mem[bad], ref_dst[bad]);
    end
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) begin
      src_mem[i] = $urandom();
      stall[i]   = 0;
    end
    src_mem[0] = 32'h11; src_mem[1] = 32'h22; src_mem[2] = 32'h33; src_mem[3] = 32'h44;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    for (int i = 0; i < SIZE; i++) ref_dst[i] = 32'hA5A5_0000 + i;
    chk("reset write_en", 64'(dst_write_en), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset src_addr0", 64'(src_addr0), 64'(0));
    chk("reset dst_addr0", 64'(dst_addr0), 64'(0));
    chk("reset write_data", 64'(dst_write_data), 64'(src_mem[0]));
    reset = 1'b0;
    tick();

    start_copy(4);
    wait_idle(100);
    check_mem("copy4");

    start_copy(0);
    chk("len0 dst_addr0", 64'(dst_addr0), 64'(0));
    wait_idle(20);
    chk("len0 src_addr0", 64'(src_addr0), 64'(0));
    check_mem("len0");

    clear_dst();
    start_copy(16);
    wait_idle(100);
    check_mem("len16");
    clear_dst();
    start_copy(31);
    wait_idle(100);
    check_mem("len31");

    clear_dst();
    stall[1] = 3;
    start_copy(3);
    wait_idle(100);
    check_mem("stall");
    stall[1] = 0;

    // Abort in cycle 6: words 0..2 stay written, the rest never arrive.
    clear_dst();
    start_copy(8);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_wr.delete();
    exp_done.delete();
    for (int i = 3; i < 8; i++) ref_dst[i] = 32'hA5A5_0000 + i;
    chk("abort write_en", 64'(dst_write_en), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort dst_addr0", 64'(dst_addr0), 64'(0));
    chk("abort write_data", 64'(dst_write_data), 64'(src_mem[0]));
    repeat (6) tick();
    check_mem("abort");
    start_copy(2);
    wait_idle(50);
    check_mem("after abort");

    // go pulsed in WAIT and held through FIN must not restart.
    clear_dst();
    start_copy(3);
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    go = 1'b1;
    repeat (4) tick();
    go = 1'b0;
    wait_idle(50);
    chk("held go idle", 64'(dst_write_en), 64'(0));
    start_copy(2);
    wait_idle(50);
    check_mem("busy go");

    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < SIZE; i++) begin
        src_mem[i] = $urandom();
        stall[i]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      clear_dst();
      start_copy(int'($urandom_range(0, 31)));
      wait_idle(200);
      check_mem("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
